stream_select_mux: RTL and testbench
====================================

# stream_select_mux

Per-stream consumer of the stream configuration: takes one (select, data_type) configuration pair per stream, connects the selected one of NUM_SELECT input data streams to a single output until the stream's last beat, then fetches the next configuration. One instance sits behind each `out[I]` channel of the stream configuration block. It tags every output beat with the configured data type.

## Interface
- NUM_SELECT, 4 — number of candidate input streams (≥2)
- DATA_BITS, 512 — data beat width
- SEL_BITS, $clog2(NUM_SELECT) — select field width; `select_t` is wider, upper bits checked for range
- clk  in  1  clock; all logic single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- conf_select_valid/ready  in/out  1  select handshake
- conf_select_data  in  select_t  requested input index
- conf_type_valid/ready  in/out  1  data-type handshake
- conf_type_data  in  type_t  data type of the stream
- in_valid[NUM_SELECT] / in_ready[NUM_SELECT]  in/out  1 each  input handshakes
- in_data[NUM_SELECT]  in  DATA_BITS  input beats
- in_last[NUM_SELECT]  in  1  end-of-stream marker
- out_valid/out_ready  out/in  1  output handshake
- out_data  out  DATA_BITS; out_last  out  1; out_type  out  type_t
- sel_error  out  1  sticky: out-of-range select received

## Operation
- States: WAIT_CONF, STREAM.
- WAIT_CONF: conf_select_ready = conf_type_ready = 1 only when both valid (joint consume). On joint handshake latch select and type into cur_sel/cur_type.
  - select < NUM_SELECT → STREAM.
  - select ≥ NUM_SELECT → pair consumed, sel_error set, stay WAIT_CONF.
- STREAM: out_valid = in_valid[cur_sel]; in_ready[cur_sel] = out_ready; all other in_ready = 0. out_data/out_last from in[cur_sel], out_type = cur_type.
- Beat with out_valid & out_ready & out_last → WAIT_CONF. Config for next stream is not accepted in that same cycle.
- Unselected inputs are never consumed; they back-pressure.
- Zero-length streams do not exist: every stream has ≥1 beat, the last carrying in_last.
- sel_error cleared only by reset.

## Timing
- Reset (async assert, sync-released internally): state = WAIT_CONF, cur_sel = 0, cur_type = 0, sel_error = 0, all in_ready = 0, out_valid = 0, conf ready = 0.
- Config → first beat: config handshake in cycle N; earliest output beat N+1.
- Data path is combinational in STREAM (zero latency, no buffering); one beat per cycle sustained.
- Last beat in cycle M → next config earliest in M+1 → next beat earliest M+2 (one bubble per stream).
- Select and type arriving in different cycles: wait, consume both together; neither ready rises alone.
- out_valid must not drop without handshake; guaranteed because upstream obeys the same rule and cur_sel is stable in STREAM.
- Reset mid-stream: immediately WAIT_CONF; partial stream is discarded from this block's view (no last emitted).

## Configuration
- STREAM_SELECT_MUX_BEAT_COUNT_EN defined: adds output beat_count (32 bits) counting beats of the current stream; cleared on entering STREAM, increments per output handshake, saturates at 2^32−1, holds its final value in WAIT_CONF. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- `select_t`, `type_t`, `stream_conf_t` and state enum in the shared config package alongside the stream configuration types.
- One sub-module natural: `stream_select_fsm` (state, config latch, sel_error); mux datapath in the top.

## Test plan
- Config (select=2, type=3), 4-beat stream on in[2] → 4 out beats with out_type=3, last on beat 4; in[0,1,3] valid held, never readied.
- Select arrives cycle 0, type cycle 5 → both consumed in cycle 5 only; first beat no earlier than cycle 6.
- Select=7 with NUM_SELECT=4 → pair consumed, sel_error=1, no output; next valid config (select=1) streams normally, sel_error stays 1.
- out_ready toggling 1/0 random over 16-beat stream → data order intact, no drops or duplicates, in_ready[sel] mirrors out_ready.
- Back-to-back configs queued, two 1-beat streams → exactly one bubble cycle between the two output beats.
- rst_n asserted mid-stream after 3 of 8 beats → all outputs reset values asynchronously; fresh config after release streams correctly; with BEAT_COUNT_EN, beat_count=0 after reset and 8 after an 8-beat stream.

Source files
------------

// File: rtl/stream_select_mux_pkg.sv
// Shared stream configuration types for the select mux and its FSM.
// Optional STREAM_SELECT_MUX_BEAT_COUNT_EN adds a per-stream beat counter.
package stream_select_mux_pkg;

    typedef logic [7:0] select_t;
    typedef logic [3:0] type_t;

    typedef struct packed {
        select_t sel;
        type_t   typ;
    } stream_conf_t;

    typedef enum logic {
        WAIT_CONF = 1'b0,
        STREAM    = 1'b1
    } sel_state_e;

    function automatic logic sel_in_range(select_t s, int n);
        return int'(s) < n;
    endfunction

endpackage

// File: rtl/stream_select_mux_if.sv
// Handshake bundle of the select mux: config pair, candidate inputs, output.
interface stream_select_mux_if
    import stream_select_mux_pkg::*;
#(
    parameter int NUM_SELECT = 4,
    parameter int DATA_BITS  = 512
);
    logic                  conf_select_valid;
    logic                  conf_select_ready;
    select_t               conf_select_data;
    logic                  conf_type_valid;
    logic                  conf_type_ready;
    type_t                 conf_type_data;
    logic [NUM_SELECT-1:0] in_valid;
    logic [NUM_SELECT-1:0] in_ready;
    logic [NUM_SELECT-1:0] in_last;
    logic [DATA_BITS-1:0]  in_data [NUM_SELECT];
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [DATA_BITS-1:0]  out_data;
    type_t                 out_type;

    modport master (
        output conf_select_valid, conf_select_data,
        output conf_type_valid, conf_type_data,
        output in_valid, in_data, in_last, out_ready,
        input  conf_select_ready, conf_type_ready,
        input  in_ready, out_valid, out_data, out_last, out_type
    );

    modport slave (
        input  conf_select_valid, conf_select_data,
        input  conf_type_valid, conf_type_data,
        input  in_valid, in_data, in_last, out_ready,
        output conf_select_ready, conf_type_ready,
        output in_ready, out_valid, out_data, out_last, out_type
    );
endinterface

// File: rtl/stream_select_fsm.sv
// Config latch and stream state for the select mux; owns sticky sel_error.
module stream_select_fsm
    import stream_select_mux_pkg::*;
#(
    parameter int NUM_SELECT = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    run,
    input  logic    sel_valid,
    input  logic    type_valid,
    input  select_t sel_data,
    input  type_t   type_data,
    input  logic    stream_done,
    output logic    conf_ready,
    output logic    streaming,
    output select_t cur_sel,
    output type_t   cur_type,
    output logic    sel_error
);
    sel_state_e   state_q, state_d;
    stream_conf_t conf_q, conf_d;
    logic         sel_error_q, sel_error_d;

    always_comb begin
        state_d     = state_q;
        conf_d      = conf_q;
        sel_error_d = sel_error_q;
        conf_ready  = 1'b0;
        case (state_q)
            WAIT_CONF: begin
                // Both halves of the pair are taken in the same cycle.
                if (run && sel_valid && type_valid) begin
                    conf_ready = 1'b1;
                    conf_d.sel = sel_data;
                    conf_d.typ = type_data;
                    if (sel_in_range(sel_data, NUM_SELECT)) begin
                        state_d = STREAM;
                    end else begin
                        sel_error_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (stream_done) begin
                    state_d = WAIT_CONF;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_CONF;
            conf_q      <= '0;
            sel_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            conf_q      <= conf_d;
            sel_error_q <= sel_error_d;
        end
    end

    assign streaming = (state_q == STREAM);
    assign cur_sel   = conf_q.sel;
    assign cur_type  = conf_q.typ;
    assign sel_error = sel_error_q;
endmodule

// File: rtl/stream_select_mux.sv
// Routes the configured input stream to the output until its last beat.
// Define STREAM_SELECT_MUX_BEAT_COUNT_EN to add the beat_count output.
module stream_select_mux
    import stream_select_mux_pkg::*;
#(
    parameter int NUM_SELECT = 4,
    parameter int DATA_BITS  = 512,
    parameter int SEL_BITS   = $clog2(NUM_SELECT)
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_select_mux_if.slave  bus,
    output logic                sel_error
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
    ,
    output logic [31:0]         beat_count
`endif
);
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                rst_ni;
    logic                armed_q, armed_d;
    logic                conf_ready;
    logic                streaming;
    logic                sel_ok;
    logic                stream_done;
    select_t             cur_sel;
    type_t               cur_type;
    logic [SEL_BITS-1:0] idx;
    logic [DATA_BITS-1:0] mux_data;

    // Assert asynchronously, release on the clock.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_ni = rst_sync_q[1];

    // Keeps conf ready low combinationally while reset is held.
    assign armed_d = 1'b1;
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) armed_q <= 1'b0;
        else         armed_q <= armed_d;
    end

    stream_select_fsm #(.NUM_SELECT(NUM_SELECT)) u_fsm (
        .clk         (clk),
        .rst_n       (rst_ni),
        .run         (armed_q),
        .sel_valid   (bus.conf_select_valid),
        .type_valid  (bus.conf_type_valid),
        .sel_data    (bus.conf_select_data),
        .type_data   (bus.conf_type_data),
        .stream_done (stream_done),
        .conf_ready  (conf_ready),
        .streaming   (streaming),
        .cur_sel     (cur_sel),
        .cur_type    (cur_type),
        .sel_error   (sel_error)
    );

    assign bus.conf_select_ready = conf_ready;
    assign bus.conf_type_ready   = conf_ready;

    assign idx    = cur_sel[SEL_BITS-1:0];
    assign sel_ok = streaming && (cur_sel == select_t'(idx));

    always_comb begin
        mux_data      = bus.in_data[idx];
        bus.out_data  = mux_data;
        bus.out_valid = sel_ok && bus.in_valid[idx];
        bus.out_last  = sel_ok && bus.in_last[idx];
        bus.out_type  = cur_type;
        bus.in_ready  = '0;
        for (int i = 0; i < NUM_SELECT; i++) begin
            bus.in_ready[i] = sel_ok && (idx == SEL_BITS'(i)) && bus.out_ready;
        end
    end

    assign stream_done = bus.out_valid && bus.out_ready && bus.out_last;

`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        start;

    assign start = bus.conf_select_ready
                && sel_in_range(bus.conf_select_data, NUM_SELECT);

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (bus.out_valid && bus.out_ready && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign beat_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_select_mux.sv
// Randomised bench for stream_select_mux with a queue-based output model.
module tb_stream_select_mux;
    import stream_select_mux_pkg::*;

    localparam int NS = 4;
    localparam int DW = 512;

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    typedef struct { logic [DW-1:0] d; logic l; type_t t; int s; } exp_t;
    typedef struct { select_t s; type_t t; int dly; } cfg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_select_mux_if #(.NUM_SELECT(NS), .DATA_BITS(DW)) bus ();
    logic sel_error;
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
    logic [31:0] beat_count;
`endif

    stream_select_mux #(.NUM_SELECT(NS), .DATA_BITS(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sel_error (sel_error)
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
        ,
        .beat_count(beat_count)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    beat_t src_q [NS][$];
    beat_t pend_q [NS][$];
    exp_t  exp_q[$];
    cfg_t  cfg_q[$];
    int    acc = 0, done_n = 0, bc_exp = 0, beats_out = 0;
    bit    err_exp = 0, flush = 0, rdy_rand = 0, gap_en = 0;
    bit    cfg_on = 0;
    int    cfg_age = 0, appear_cyc = 0, conf_cyc = 0;
    int    log_cyc[$];
    type_t log_typ[$];
    bit    log_last[$];
    bit    hs_c, hs_o, act;
    logic [NS-1:0] hs_i, exp_ir;
    int    hsel;

    task automatic chk(string nm, bit ok, logic [63:0] a, logic [63:0] e);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic add_src(int s, int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
            b.l = (k == n - 1);
            src_q[s].push_back(b);
            pend_q[s].push_back(b);
        end
    endtask

    task automatic add_cfg(int s, int t, int dly);
        cfg_t  c;
        beat_t b;
        exp_t  e;
        c.s = select_t'(s);
        c.t = type_t'(t);
        c.dly = dly;
        cfg_q.push_back(c);
        if (s < NS) begin
            do begin
                if (pend_q[s].size() == 0) break;
                b = pend_q[s].pop_front();
                e.d = b.d; e.l = b.l; e.t = type_t'(t); e.s = s;
                exp_q.push_back(e);
            end while (!b.l);
        end
    endtask

    task automatic add_stream(int s, int t, int n, int dly);
        add_src(s, n);
        add_cfg(s, t, dly);
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((cfg_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= budget) chk("idle_timeout", 1'b0, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        #2;
    endtask

    // Driver and per-cycle compare against the queue model.
    initial begin
        bus.conf_select_valid = 0; bus.conf_type_valid = 0;
        bus.conf_select_data = '0; bus.conf_type_data = '0;
        bus.in_valid = '0; bus.in_last = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < NS; i++) bus.in_data[i] = '0;
        forever begin
            @(negedge clk);
            hs_c = bus.conf_select_valid && bus.conf_select_ready;
            hs_o = bus.out_valid && bus.out_ready;
            hs_i = bus.in_valid & bus.in_ready;
            if (!rst_n) begin
                chk("rst_outs", !bus.out_valid && bus.in_ready == '0
                    && !bus.conf_select_ready && !bus.conf_type_ready
                    && !sel_error, 64'(bus.in_ready), 64'd0);
            end else if (!flush) begin
                chk("conf_joint", (bus.conf_select_ready == bus.conf_type_ready)
                    && (!bus.conf_select_ready
                        || (bus.conf_select_valid && bus.conf_type_valid)),
                    {62'd0, bus.conf_select_ready, bus.conf_type_ready}, 64'd0);
                act = (acc > done_n) && (exp_q.size() > 0);
                hsel = act ? exp_q[0].s : 0;
                exp_ir = (act && bus.out_ready) ? (NS'(1) << hsel) : '0;
                chk("in_ready", bus.in_ready == exp_ir, 64'(bus.in_ready), 64'(exp_ir));
                chk("out_valid", bus.out_valid == (act && bus.in_valid[hsel]),
                    64'(bus.out_valid), 64'(act && bus.in_valid[hsel]));
                if (bus.out_valid && act) begin
                    chk("out_beat", bus.out_data == exp_q[0].d
                        && bus.out_last == exp_q[0].l && bus.out_type == exp_q[0].t,
                        bus.out_data[63:0], exp_q[0].d[63:0]);
                end
                chk("sel_error", sel_error == err_exp, 64'(sel_error), 64'(err_exp));
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
                chk("beat_count", beat_count == 32'(bc_exp), 64'(beat_count), 64'(bc_exp));
`endif
                if (hs_c) conf_cyc = cyc;
                if (hs_o) begin
                    log_cyc.push_back(cyc);
                    log_typ.push_back(bus.out_type);
                    log_last.push_back(bus.out_last);
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (flush) begin
                for (int i = 0; i < NS; i++) begin
                    src_q[i].delete();
                    pend_q[i].delete();
                end
                exp_q.delete(); cfg_q.delete();
                acc = 0; done_n = 0; bc_exp = 0; err_exp = 0;
                cfg_on = 0; bus.in_valid = '0; flush = 0;
            end else begin
                if (hs_c && cfg_q.size() > 0) begin
                    if (int'(cfg_q[0].s) < NS) begin
                        acc++;
                        bc_exp = 0;
                    end else begin
                        err_exp = 1;
                    end
                    void'(cfg_q.pop_front());
                    cfg_on = 0;
                end
                for (int i = 0; i < NS; i++) begin
                    if (hs_i[i] && src_q[i].size() > 0) begin
                        void'(src_q[i].pop_front());
                        bus.in_valid[i] = 1'b0;
                    end
                end
                if (hs_o && exp_q.size() > 0) begin
                    if (exp_q[0].l) done_n++;
                    void'(exp_q.pop_front());
                    beats_out++;
                    bc_exp++;
                end
            end
            if (cfg_q.size() > 0) begin
                if (!cfg_on) begin
                    cfg_on = 1; cfg_age = 0; appear_cyc = cyc;
                end else begin
                    cfg_age++;
                end
                bus.conf_select_valid = 1'b1;
                bus.conf_select_data = cfg_q[0].s;
                bus.conf_type_data = cfg_q[0].t;
                bus.conf_type_valid = (cfg_age >= cfg_q[0].dly);
            end else begin
                bus.conf_select_valid = 1'b0;
                bus.conf_type_valid = 1'b0;
            end
            bus.out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
            for (int i = 0; i < NS; i++) begin
                if (src_q[i].size() > 0) begin
                    if (!bus.in_valid[i])
                        bus.in_valid[i] = gap_en ? ($urandom_range(3) != 0) : 1'b1;
                    bus.in_data[i] = src_q[i][0].d;
                    bus.in_last[i] = src_q[i][0].l;
                end else begin
                    bus.in_valid[i] = 1'b0;
                    bus.in_last[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        int base, b0, n, s;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        repeat (4) @(negedge clk);
        #2;
        chk("reset_sel_error", sel_error == 1'b0, 64'(sel_error), 64'd0);

        add_src(0, 1); add_src(1, 1); add_src(3, 1);
        base = log_typ.size();
        add_stream(2, 3, 4, 0);
        wait_idle(200);
        chk("t1_beats", log_typ.size() - base == 4, 64'(log_typ.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < log_typ.size()) begin
                chk("t1_type", log_typ[base+k] == 4'd3, 64'(log_typ[base+k]), 64'd3);
                chk("t1_last", log_last[base+k] == (k == 3), 64'(log_last[base+k]), 64'(k == 3));
            end
        end
        add_cfg(0, 1, 0); add_cfg(1, 1, 0); add_cfg(3, 1, 0);
        wait_idle(200);

        add_src(1, 2);
        base = log_cyc.size();
        add_cfg(1, 6, 5);
        wait_idle(200);
        chk("t2_conf_wait", conf_cyc - appear_cyc == 5, 64'(conf_cyc - appear_cyc), 64'd5);
        if (base < log_cyc.size())
            chk("t2_first_beat", log_cyc[base] - conf_cyc == 1, 64'(log_cyc[base] - conf_cyc), 64'd1);

        add_cfg(7, 5, 0);
        base = log_typ.size();
        add_stream(1, 2, 3, 0);
        wait_idle(200);
        chk("t3_sel_error", sel_error == 1'b1, 64'(sel_error), 64'd1);
        chk("t3_beats", log_typ.size() - base == 3, 64'(log_typ.size() - base), 64'd3);
        if (base < log_typ.size())
            chk("t3_type", log_typ[base] == 4'd2, 64'(log_typ[base]), 64'd2);

        rdy_rand = 1;
        base = log_typ.size();
        add_stream(0, 4, 16, 0);
        wait_idle(400);
        rdy_rand = 0;
        chk("t4_beats", log_typ.size() - base == 16, 64'(log_typ.size() - base), 64'd16);

        base = log_cyc.size();
        add_stream(0, 1, 1, 0);
        add_stream(3, 2, 1, 0);
        wait_idle(200);
        if (base + 1 < log_cyc.size())
            chk("t5_bubble", log_cyc[base+1] - log_cyc[base] == 2,
                64'(log_cyc[base+1] - log_cyc[base]), 64'd2);
        else
            chk("t5_beats", 1'b0, 64'(log_cyc.size() - base), 64'd2);

        b0 = beats_out;
        add_stream(2, 7, 8, 0);
        n = 0;
        while (beats_out < b0 + 3 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        chk("t6_pre_beats", beats_out == b0 + 3, 64'(beats_out - b0), 64'd3);
        rst_n = 0;
        flush = 1;
        #1;
        chk("t6_async_rst", !bus.out_valid && bus.in_ready == '0
            && !bus.conf_select_ready && !sel_error,
            {bus.out_valid, 59'd0, bus.in_ready}, 64'd0);
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
        chk("t6_count_rst", beat_count == 32'd0, 64'(beat_count), 64'd0);
`endif
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        repeat (2) @(negedge clk);
        #2;
        base = log_typ.size();
        add_stream(2, 9, 8, 0);
        wait_idle(300);
        chk("t6_beats", log_typ.size() - base == 8, 64'(log_typ.size() - base), 64'd8);
        chk("t6_sel_error", sel_error == 1'b0, 64'(sel_error), 64'd0);
`ifdef STREAM_SELECT_MUX_BEAT_COUNT_EN
        chk("t6_count", beat_count == 32'd8, 64'(beat_count), 64'd8);
`endif

        gap_en = 1;
        rdy_rand = 1;
        for (int k = 0; k < 24; k++) begin
            s = $urandom_range(5);
            if (s < NS) add_src(s, $urandom_range(1, 6));
            add_cfg(s, $urandom_range(15), $urandom_range(3));
        end
        wait_idle(4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
